// File: rtl/sap_cpu_p_pkg.sv
// ============================================================================
// sap_pkg : opcodes, microstep encoding and instruction field helpers
// Rev 1.0 : initial parametrised release
// ============================================================================
`default_nettype none

package sap_pkg;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_OUT = 4'h3;
    localparam logic [3:0] OP_SUB = 4'h4;
    localparam logic [3:0] OP_STA = 4'h5;
    localparam logic [3:0] OP_LDI = 4'h6;
    localparam logic [3:0] OP_JMP = 4'h7;
    localparam logic [3:0] OP_JC  = 4'h8;
    localparam logic [3:0] OP_JZ  = 4'h9;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [2:0] {
        T0 = 3'd0,
        T1 = 3'd1,
        T2 = 3'd2,
        T3 = 3'd3,
        T4 = 3'd4
    } step_t;

    // Callers zero-extend the word to 64 bits and pass their own widths.
    function automatic logic [3:0] get_opcode(input logic [63:0] word,
                                              input int unsigned data_w);
        return 4'(word >> (data_w - 4));
    endfunction

    function automatic logic [63:0] get_operand(input logic [63:0] word,
                                                input int unsigned addr_w);
        return word & ((64'd1 << addr_w) - 64'd1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/sap_cpu_p_alu.sv
// ============================================================================
// sap_alu : combinational add/subtract with carry and zero flags
// Rev 1.0 : initial parametrised release
// ============================================================================
`default_nettype none

module sap_alu #(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              sub,
    output logic [DATA_W-1:0] result,
    output logic              c,
    output logic              z
);

    logic [DATA_W-1:0] w_b_eff;
    logic [DATA_W:0]   w_sum;

    // Subtract as A + ~B + 1, so carry out means "no borrow".
    assign w_b_eff = sub ? ~b : b;
    assign w_sum   = {1'b0, a} + {1'b0, w_b_eff} + (DATA_W+1)'(sub);
    assign result  = w_sum[DATA_W-1:0];
    assign c       = w_sum[DATA_W];
    assign z       = (w_sum[DATA_W-1:0] == '0);

endmodule

`default_nettype wire

// File: rtl/sap_cpu_p.sv
// ============================================================================
// sap_cpu_p : multicycle microcoded accumulator CPU with unified RAM
// Rev 1.0 : initial parametrised release
// ============================================================================
`default_nettype none

module sap_cpu_p
    import sap_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              step_en,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              halted,
    output logic [ADDR_W-1:0] pc_o
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [0:DEPTH-1];

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] mar_q;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic [DATA_W-1:0] ir_q;
    logic [DATA_W-1:0] out_data_q;
    logic              c_q;
    logic              z_q;
    logic              halted_q;
    logic              out_valid_q;
    step_t             step_q;

    logic [3:0]        w_opcode;
    logic [ADDR_W-1:0] w_operand;
    logic [DATA_W-1:0] w_ram_rd;
    logic              w_advance;
    logic              w_sta_we;
    logic [DATA_W-1:0] w_alu_res;
    logic              w_alu_c;
    logic              w_alu_z;

    assign w_opcode  = get_opcode(64'(ir_q), DATA_W);
    assign w_operand = ADDR_W'(get_operand(64'(ir_q), ADDR_W));
    assign w_ram_rd  = mem_q[mar_q];
    assign w_advance = step_en && !halted_q;
    // Reset gating keeps an abandoned STA from landing in RAM.
    assign w_sta_we  = rst_n && w_advance && (step_q == T3) && (w_opcode == OP_STA);

    sap_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .a      (a_q),
        .b      (b_q),
        .sub    (w_opcode == OP_SUB),
        .result (w_alu_res),
        .c      (w_alu_c),
        .z      (w_alu_z)
    );

    // The load port outranks a same-edge STA and is live through reset and halt.
    always_ff @(posedge clk) begin
        if (prog_we) begin
            mem_q[prog_addr] <= prog_data;
        end else if (w_sta_we) begin
            mem_q[mar_q] <= a_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q        <= '0;
            mar_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            ir_q        <= '0;
            out_data_q  <= '0;
            c_q         <= 1'b0;
            z_q         <= 1'b0;
            halted_q    <= 1'b0;
            out_valid_q <= 1'b0;
            step_q      <= T0;
        end else begin
            out_valid_q <= 1'b0;
            if (w_advance) begin
                unique case (step_q)
                    T0: begin
                        mar_q  <= pc_q;
                        step_q <= T1;
                    end
                    T1: begin
                        ir_q   <= w_ram_rd;
                        pc_q   <= pc_q + ADDR_W'(1);
                        step_q <= T2;
                    end
                    T2: begin
                        step_q <= T0;
                        case (w_opcode)
                            OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                                mar_q  <= w_operand;
                                step_q <= T3;
                            end
                            OP_LDI: a_q <= DATA_W'(w_operand);
                            OP_JMP: pc_q <= w_operand;
                            OP_JC:  if (c_q) pc_q <= w_operand;
                            OP_JZ:  if (z_q) pc_q <= w_operand;
                            OP_OUT: begin
                                out_data_q  <= a_q;
                                out_valid_q <= 1'b1;
                            end
                            OP_HLT: halted_q <= 1'b1;
                            default: ;
                        endcase
                    end
                    T3: begin
                        step_q <= T0;
                        case (w_opcode)
                            OP_LDA: a_q <= w_ram_rd;
                            OP_ADD, OP_SUB: begin
                                b_q    <= w_ram_rd;
                                step_q <= T4;
                            end
                            default: ;
                        endcase
                    end
                    T4: begin
                        a_q    <= w_alu_res;
                        c_q    <= w_alu_c;
                        z_q    <= w_alu_z;
                        step_q <= T0;
                    end
                    default: step_q <= T0;
                endcase
            end
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign halted    = halted_q;
    assign pc_o      = pc_q;

endmodule

`default_nettype wire

// File: tb/tb_sap_cpu_p.sv
// ============================================================================
// tb_sap_cpu_p : directed programs with an output scoreboard for sap_cpu_p
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_sap_cpu_p;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       step_en;
    logic       prog_we;
    logic [3:0] prog_addr;
    logic [7:0] prog_data;
    logic [7:0] out_data;
    logic       out_valid;
    logic       halted;
    logic [3:0] pc_o;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [7:0] exp_q[$];
    logic [7:0] prog [16];
    logic [7:0] mon_exp;

    always #5 clk = ~clk;

    sap_cpu_p #(
        .DATA_W (8),
        .ADDR_W (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .step_en   (step_en),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .out_data  (out_data),
        .out_valid (out_valid),
        .halted    (halted),
        .pc_o      (pc_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    // Scoreboard monitor: every OUT pulse pops one expected value.
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            tests_run++;
            if (exp_q.size() == 0) begin
                tests_failed++;
                $display("FAIL out_unexpected: got 0x%0h, expected no output", out_data);
            end else begin
                mon_exp = exp_q.pop_front();
                if (out_data !== mon_exp) begin
                    tests_failed++;
                    $display("FAIL out_data: got 0x%0h, expected 0x%0h", out_data, mon_exp);
                end
            end
        end
    end

    task automatic clear_prog();
        for (int i = 0; i < 16; i++) prog[i] = 8'h00;
    endtask

    task automatic load_prog1();
        clear_prog();
        prog[0]  = 8'h1E;   // LDA 14
        prog[1]  = 8'h2F;   // ADD 15
        prog[2]  = 8'h30;   // OUT
        prog[3]  = 8'hF0;   // HLT
        prog[14] = 8'h05;
        prog[15] = 8'h03;
    endtask

    // Holds reset while loading all 16 words, leaving the core in reset.
    task automatic load_and_reset();
        rst_n   = 1'b0;
        step_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            prog_we   = 1'b1;
            prog_addr = 4'(i);
            prog_data = prog[i];
            tick();
        end
        prog_we = 1'b0;
        tick();
    endtask

    task automatic run_to_halt(input string name);
        int n;
        n = 0;
        while (halted !== 1'b1 && n < 300) begin
            tick();
            n++;
        end
        ticks(2);
        chk({name, " halted"}, 32'(halted), 32'd1);
        chk({name, " outputs drained"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        step_en   = 1'b0;
        prog_we   = 1'b0;
        prog_addr = '0;
        prog_data = '0;

        // ---- Program 1: LDA/ADD/OUT/HLT, edge-exact timing ----
        load_prog1();
        load_and_reset();
        chk("reset pc_o", 32'(pc_o), 32'd0);
        chk("reset out_data", 32'(out_data), 32'd0);
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset halted", 32'(halted), 32'd0);
        exp_q.push_back(8'h08);
        rst_n = 1'b1;
        ticks(11);
        chk("p1 out_valid before edge12", 32'(out_valid), 32'd0);
        tick();
        chk("p1 out_valid edge12", 32'(out_valid), 32'd1);
        chk("p1 out_data edge12", 32'(out_data), 32'h08);
        tick();
        chk("p1 out_valid edge13", 32'(out_valid), 32'd0);
        tick();
        chk("p1 halted edge14", 32'(halted), 32'd0);
        tick();
        chk("p1 halted edge15", 32'(halted), 32'd1);
        ticks(5);
        chk("p1 pc_o after halt", 32'(pc_o), 32'd4);
        run_to_halt("p1");

        // ---- Program 2: ADD overflow, Z and C taken ----
        clear_prog();
        prog[0]  = 8'h1E;   // LDA 14
        prog[1]  = 8'h2F;   // ADD 15 -> 0x00, C=1, Z=1
        prog[2]  = 8'h99;   // JZ 9
        prog[3]  = 8'h61;   // LDI 1 (wrong path)
        prog[4]  = 8'h30;
        prog[5]  = 8'hF0;
        prog[9]  = 8'h30;   // OUT -> 0x00
        prog[10] = 8'h8C;   // JC 12
        prog[11] = 8'hF0;
        prog[12] = 8'h6C;   // LDI 12
        prog[13] = 8'h30;   // OUT -> 0x0C
        prog[14] = 8'hFF;   // data, also decodes as HLT
        prog[15] = 8'h01;
        load_and_reset();
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h0C);
        rst_n = 1'b1;
        ticks(12);
        chk("p2 pc after JZ", 32'(pc_o), 32'd9);
        run_to_halt("p2");
        chk("p2 final pc", 32'(pc_o), 32'd15);

        // ---- Program 3: SUB with borrow, JC/JZ not taken ----
        clear_prog();
        prog[0]  = 8'h63;   // LDI 3
        prog[1]  = 8'h4F;   // SUB 15 -> 0xFE, C=0, Z=0
        prog[2]  = 8'h88;   // JC 8
        prog[3]  = 8'h30;   // OUT -> 0xFE
        prog[4]  = 8'h98;   // JZ 8
        prog[5]  = 8'h65;   // LDI 5
        prog[6]  = 8'h30;   // OUT -> 0x05
        prog[7]  = 8'hF0;
        prog[8]  = 8'h6E;
        prog[9]  = 8'h30;
        prog[10] = 8'hF0;
        prog[15] = 8'h05;
        load_and_reset();
        exp_q.push_back(8'hFE);
        exp_q.push_back(8'h05);
        rst_n = 1'b1;
        ticks(11);
        chk("p3 pc after JC", 32'(pc_o), 32'd3);
        run_to_halt("p3");
        chk("p3 final pc", 32'(pc_o), 32'd8);

        // ---- Program 4: STA round trip ----
        clear_prog();
        prog[0] = 8'h67;    // LDI 7
        prog[1] = 8'h5D;    // STA 13
        prog[2] = 8'h60;    // LDI 0
        prog[3] = 8'h1D;    // LDA 13
        prog[4] = 8'h30;    // OUT -> 0x07
        prog[5] = 8'hF0;
        load_and_reset();
        exp_q.push_back(8'h07);
        rst_n = 1'b1;
        ticks(6);
        chk("p4 ram13 before STA T3", 32'(dut.mem_q[13]), 32'h00);
        tick();
        chk("p4 ram13 after STA T3", 32'(dut.mem_q[13]), 32'h07);
        run_to_halt("p4");

        // ---- Program 1 with step_en toggling every clk ----
        load_prog1();
        load_and_reset();
        exp_q.push_back(8'h08);
        rst_n   = 1'b1;
        step_en = 1'b1;
        for (int e = 1; e <= 32; e++) begin
            tick();
            step_en = ~step_en;
            if (e == 22) chk("p5 out_valid edge22", 32'(out_valid), 32'd0);
            if (e == 23) chk("p5 out_valid edge23", 32'(out_valid), 32'd1);
            if (e == 24) chk("p5 out_valid edge24", 32'(out_valid), 32'd0);
            if (e == 28) chk("p5 halted edge28", 32'(halted), 32'd0);
            if (e == 29) chk("p5 halted edge29", 32'(halted), 32'd1);
        end
        step_en = 1'b1;
        chk("p5 pc_o", 32'(pc_o), 32'd4);
        chk("p5 A", 32'(dut.a_q), 32'h08);
        chk("p5 B", 32'(dut.b_q), 32'h03);
        chk("p5 out_data held", 32'(out_data), 32'h08);
        run_to_halt("p5");

        // ---- Reset during ADD T3 with a same-edge program write ----
        load_prog1();
        load_and_reset();
        rst_n = 1'b1;
        ticks(7);
        rst_n     = 1'b0;
        prog_we   = 1'b1;
        prog_addr = 4'd15;
        prog_data = 8'h10;
        tick();
        prog_we = 1'b0;
        chk("p6 pc after reset", 32'(pc_o), 32'd0);
        chk("p6 A after reset", 32'(dut.a_q), 32'd0);
        chk("p6 halted after reset", 32'(halted), 32'd0);
        chk("p6 ram15 loaded", 32'(dut.mem_q[15]), 32'h10);
        exp_q.push_back(8'h15);
        rst_n = 1'b1;
        run_to_halt("p6");
        chk("p6 out_data", 32'(out_data), 32'h15);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sap_cpu_p.md
# sap_cpu_p

- Parametrised successor to the team's fixed 8-bit accumulator CPU; a multicycle microcoded core with internal unified program/data RAM.
- Generalised in data width and address depth; adds SUB, STA, LDI, JMP, JC, JZ and HLT, plus carry/zero flags.
- Uses variable-length instructions with no dead microsteps, and has a program-load port.
- Advances only on an external `step_en` qualifier, so the board-level divider sits outside the core.

## Interface

Parameters:
- DATA_W, 8, width of the accumulator, B register, RAM words and bus. Must satisfy DATA_W >= ADDR_W + 4.
- ADDR_W, 4, width of the RAM address and PC. RAM depth is 2**ADDR_W.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  synchronous, active-low reset.
- step_en  in  1  microstep qualifier; the CPU state (PC, A, B, IR, MAR, flags, step, halted, out_*) holds when low.
- prog_we  in  1  RAM write strobe for program loading; independent of step_en.
- prog_addr  in  ADDR_W  program-load address.
- prog_data  in  DATA_W  program-load data.
- out_data  out  DATA_W  output register.
- out_valid  out  1  one-clk pulse when out_data is updated by OUT.
- halted  out  1  high after HLT executes.
- pc_o  out  ADDR_W  current PC, for debug.

## Operation

**Instruction format**
- Opcode is word[DATA_W-1:DATA_W-4].
- Operand is word[ADDR_W-1:0].
- Any bits between them are ignored.

**Opcodes** (existing encodings are kept)
- NOP=0x0, LDA=0x1, ADD=0x2, OUT=0x3, SUB=0x4, STA=0x5, LDI=0x6, JMP=0x7, JC=0x8, JZ=0x9, HLT=0xF.
- All other opcodes execute as NOP.

**Microsteps**
- Each microstep consumes one clk cycle with step_en=1.
- T0: MAR<=PC.
- T1: IR<=RAM[MAR]; PC<=PC+1 (wraps mod 2**ADDR_W).
- Execute steps per opcode:
  - LDA: T2 MAR<=op; T3 A<=RAM[MAR]. 4 steps.
  - ADD/SUB: T2 MAR<=op; T3 B<=RAM[MAR]; T4 A<=result and flags update. 5 steps.
  - STA: T2 MAR<=op; T3 RAM[MAR]<=A. 4 steps.
  - LDI: T2 A<=zero-extended op. 3 steps.
  - JMP: T2 PC<=op. 3 steps.
  - JC/JZ: T2 PC<=op if C/Z set, else no change. 3 steps.
  - OUT: T2 out_data<=A, out_valid<=1. 3 steps.
  - HLT: T2 halted<=1. 3 steps.
  - NOP: T2 idle. 3 steps.
- The step after an instruction's last step is T0.

**Arithmetic**
- ADD computes the DATA_W+1-bit sum A+B; C is the carry out.
- SUB computes A+~B+1; C=1 means no borrow (A>=B unsigned).
- Z=1 when the DATA_W-bit result is 0.
- Only ADD and SUB change the flags.

**RAM and halt**
- RAM reads are asynchronous.
- When halted=1, the step counter freezes; only rst_n clears halted.
- prog_we writes RAM[prog_addr] on any edge, halted or in reset included.
- prog_we takes priority over a same-edge STA write to any address. The STA data is dropped.
- Reset does not clear RAM.

## Timing

- Reset values: PC=0, A=0, B=0, IR=0, MAR=0, C=0, Z=0, step=T0, halted=0, out_data=0, out_valid=0, pc_o=0.
- Reset wins over step_en and over all microsteps. Reset mid-instruction abandons the instruction with no partial RAM write; the next instruction fetched is RAM[0].
- out_valid:
  - Asserts on the edge ending OUT T2 and deasserts on the next clk edge, regardless of step_en.
  - It is high for exactly 1 clk even when step_en is sparse.
- Jumps take effect on the fetch of the next instruction. There is no delay slot.
- A JC/JZ immediately after ADD/SUB sees the flags written by that instruction's T4.
- With step_en tied high, CPI is 3/4/5 clk per instruction as listed above.

## Structure

- Package sap_pkg holds:
  - the opcode localparams (4-bit);
  - the step encoding (T0..T4, enum, 3 bits);
  - the opcode and operand field extraction functions, parametrised by DATA_W/ADDR_W.
- Sub-module sap_alu (combinational): inputs a, b, sub; outputs result[DATA_W-1:0], c, z.
- The top contains the microstep FSM, the register file, RAM and the load port.

## Test plan

All scenarios use defaults and step_en=1 unless stated.

1. Load RAM[0..3] = LDA 14, ADD 15, OUT, HLT with RAM[14]=0x05, RAM[15]=0x03, release reset.
   - out_valid pulses for 1 clk after the 12th edge with out_data=0x08.
   - halted=1 after the 15th edge.
   - pc_o stays 4 thereafter.
2. A=0xFF via LDI/LDA, then ADD a word of 0x01.
   - A=0x00, C=1, Z=1.
   - A following JZ 9 sets PC=9.
3. A=0x03, then SUB a word of 0x05.
   - A=0xFE, C=0, Z=0.
   - A following JC is not taken (PC=next sequential).
4. LDI 7; STA 13; LDI 0; LDA 13; OUT.
   - out_data=0x07.
   - RAM[13]=0x07 after the STA's T3.
5. Program 1 with step_en toggling 1/0 every clk.
   - out_valid rises once only (after the 23rd edge) and is 1 clk wide.
   - All register values match program 1.
6. Assert rst_n=0 during ADD T3 for one edge, while prog_we writes RAM[15]=0x10 on the same edge, then release.
   - PC=0, A=0, halted=0.
   - The rerun gives out_data=0x15.
